// File: rtl/traffic_pkg.sv
// Shared constants for the traffic-light controller and its timer/sensor front end.
package traffic_pkg;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } ctrl_state_t;

    localparam int CNT_W_DEF       = 8;
    localparam int SHORT_TICKS_DEF = 5;
    localparam int LONG_TICKS_DEF  = 25;

    localparam logic CFG_SEL_SHORT = 1'b0;
    localparam logic CFG_SEL_LONG  = 1'b1;

endpackage

// File: rtl/traffic_timer_frontend_debounce.sv
// Two-flop synchroniser plus debounce counter for one asynchronous sensor line.
module sensor_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic clean
);

    localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
    localparam logic [DW-1:0] CNT_LAST = DW'(DB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [DW-1:0] r_cnt;
    logic          r_clean;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    // The output only follows the synced line after it has disagreed for DB_CYCLES edges in a row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_clean <= 1'b0;
        end else if (r_sync2 == r_clean) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_clean <= ~r_clean;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign clean = r_clean;

endmodule

// File: rtl/traffic_timer_frontend.sv
// Interval timer producing TS/TL for the traffic controller, plus debounced C/N/P sensor inputs.
module traffic_timer_frontend
    import traffic_pkg::*;
#(
    parameter int CLK_PER_TICK = 1000,
    parameter int SHORT_TICKS  = SHORT_TICKS_DEF,
    parameter int LONG_TICKS   = LONG_TICKS_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int DB_CYCLES    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st,
    input  logic             cfg_we,
    input  logic             cfg_sel,
    input  logic [CNT_W-1:0] cfg_data,
    input  logic             c_raw,
    input  logic             n_raw,
    input  logic             p_raw,
    output logic             ts,
    output logic             tl,
    output logic             c,
    output logic             n,
    output logic             p,
    output logic [CNT_W-1:0] tick_cnt
);

    localparam int PW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_PER_TICK - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] LIM_MIN    = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [PW-1:0]    r_presc;
    logic [CNT_W-1:0] r_tick_cnt;
    logic [CNT_W-1:0] r_short_lim;
    logic [CNT_W-1:0] r_long_lim;
    logic             w_tick;
    logic [CNT_W-1:0] w_cfg_val;

    assign w_tick = (r_presc == PRESC_LAST);

    // Restart wins over a coincident tick; the tick count saturates instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc    <= '0;
            r_tick_cnt <= '0;
        end else if (st) begin
            r_presc    <= '0;
            r_tick_cnt <= '0;
        end else begin
            if (w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            if (w_tick && (r_tick_cnt != CNT_MAX)) begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
        end
    end

    // A zero limit would make the interval expire during restart, so it is clamped to one tick.
    assign w_cfg_val = (cfg_data == '0) ? LIM_MIN : cfg_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_short_lim <= CNT_W'(SHORT_TICKS);
            r_long_lim  <= CNT_W'(LONG_TICKS);
        end else if (cfg_we) begin
            if (cfg_sel == CFG_SEL_LONG) begin
                r_long_lim <= w_cfg_val;
            end else begin
                r_short_lim <= w_cfg_val;
            end
        end
    end

    assign ts       = (r_tick_cnt >= r_short_lim);
    assign tl       = (r_tick_cnt >= r_long_lim);
    assign tick_cnt = r_tick_cnt;

    sensor_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_c (
        .clk   (clk),
        .reset (reset),
        .raw   (c_raw),
        .clean (c)
    );

    sensor_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_n (
        .clk   (clk),
        .reset (reset),
        .raw   (n_raw),
        .clean (n)
    );

    sensor_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_p (
        .clk   (clk),
        .reset (reset),
        .raw   (p_raw),
        .clean (p)
    );

endmodule

// File: tb/tb_traffic_timer_frontend.sv
// Directed and randomized checks of traffic_timer_frontend against an elapsed-time reference model.
module tb_traffic_timer_frontend;

    localparam int CPT   = 4;
    localparam int SHORT = 3;
    localparam int LONG  = 6;
    localparam int CW    = 4;
    localparam int DB    = 4;
    localparam int SAT   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          st;
    logic          cfg_we;
    logic          cfg_sel;
    logic [CW-1:0] cfg_data;
    logic          c_raw;
    logic          n_raw;
    logic          p_raw;
    logic          ts;
    logic          tl;
    logic          c;
    logic          n;
    logic          p;
    logic [CW-1:0] tick_cnt;

    int nAsserts = 0;
    int nFails   = 0;

    int mElapsed;
    int mShort;
    int mLong;
    bit mClean[3];
    int mRun[3];
    bit mPipe[3][$];

    traffic_timer_frontend #(
        .CLK_PER_TICK (CPT),
        .SHORT_TICKS  (SHORT),
        .LONG_TICKS   (LONG),
        .CNT_W        (CW),
        .DB_CYCLES    (DB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .st       (st),
        .cfg_we   (cfg_we),
        .cfg_sel  (cfg_sel),
        .cfg_data (cfg_data),
        .c_raw    (c_raw),
        .n_raw    (n_raw),
        .p_raw    (p_raw),
        .ts       (ts),
        .tl       (tl),
        .c        (c),
        .n        (n),
        .p        (p),
        .tick_cnt (tick_cnt)
    );

    always #5 clk = ~clk;

    function automatic void modelReset();
        mElapsed = 0;
        mShort   = SHORT;
        mLong    = LONG;
        for (int i = 0; i < 3; i++) begin
            mClean[i] = 1'b0;
            mRun[i]   = 0;
            mPipe[i].delete();
            mPipe[i].push_back(1'b0);
            mPipe[i].push_back(1'b0);
        end
    endfunction

    // Timer is tracked as clock edges since restart; each sensor is seen two edges late and
    // the output adopts it once it has disagreed for DB consecutive edges.
    function automatic void modelEdge(bit stV, bit weV, bit selV, int dataV, bit r0, bit r1, bit r2);
        bit raws[3];
        bit seen;
        int v;
        raws[0] = r0;
        raws[1] = r1;
        raws[2] = r2;
        if (stV) mElapsed = 0;
        else if (mElapsed < 10000) mElapsed++;
        if (weV) begin
            v = (dataV == 0) ? 1 : dataV;
            if (selV) mLong = v;
            else mShort = v;
        end
        for (int i = 0; i < 3; i++) begin
            seen = mPipe[i].pop_front();
            mPipe[i].push_back(raws[i]);
            if (seen == mClean[i]) begin
                mRun[i] = 0;
            end else begin
                mRun[i]++;
                if (mRun[i] == DB) begin
                    mClean[i] = seen;
                    mRun[i]   = 0;
                end
            end
        end
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        int expCnt;
        expCnt = mElapsed / CPT;
        if (expCnt > SAT) expCnt = SAT;
        check("tick_cnt", 8'(tick_cnt), 8'(expCnt));
        check("ts", 8'(ts), 8'(expCnt >= mShort));
        check("tl", 8'(tl), 8'(expCnt >= mLong));
        check("c", 8'(c), 8'(mClean[0]));
        check("n", 8'(n), 8'(mClean[1]));
        check("p", 8'(p), 8'(mClean[2]));
    endtask

    // One clock edge: capture driven inputs, advance the model, then compare after the edge.
    task automatic applyStimulus();
        bit rstV, stV, weV, selV, r0, r1, r2;
        int dataV;
        rstV  = reset;
        stV   = st;
        weV   = cfg_we;
        selV  = cfg_sel;
        dataV = int'(cfg_data);
        r0    = c_raw;
        r1    = n_raw;
        r2    = p_raw;
        @(posedge clk);
        if (rstV) modelReset();
        else modelEdge(stV, weV, selV, dataV, r0, r1, r2);
        #1;
        checkOutput();
    endtask

    task automatic setRaw(input int idx, input logic v);
        case (idx)
            0:       c_raw = v;
            1:       n_raw = v;
            default: p_raw = v;
        endcase
    endtask

    task automatic checkSensor(input int idx, input logic exp);
        case (idx)
            0:       check("c_debounce", 8'(c), 8'(exp));
            1:       check("n_debounce", 8'(n), 8'(exp));
            default: check("p_debounce", 8'(p), 8'(exp));
        endcase
    endtask

    initial begin
        reset    = 1'b1;
        st       = 1'b0;
        cfg_we   = 1'b0;
        cfg_sel  = 1'b0;
        cfg_data = '0;
        c_raw    = 1'b0;
        n_raw    = 1'b0;
        p_raw    = 1'b0;
        modelReset();
        #12;
        checkOutput();
        applyStimulus();
        applyStimulus();
        reset = 1'b0;

        st = 1'b1;
        applyStimulus();
        st = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            applyStimulus();
            if (k == 11) check("ts_before_12", 8'(ts), 8'd0);
            if (k == 12) begin
                check("ts_at_12", 8'(ts), 8'd1);
                check("cnt_at_12", 8'(tick_cnt), 8'd3);
            end
            if (k == 23) check("tl_before_24", 8'(tl), 8'd0);
            if (k == 24) begin
                check("tl_at_24", 8'(tl), 8'd1);
                check("cnt_at_24", 8'(tick_cnt), 8'd6);
            end
        end

        st = 1'b1;
        applyStimulus();
        check("restart_ts", 8'(ts), 8'd0);
        check("restart_tl", 8'(tl), 8'd0);
        check("restart_cnt", 8'(tick_cnt), 8'd0);
        for (int k = 0; k < 20; k++) applyStimulus();
        check("hold_st_ts", 8'(ts), 8'd0);
        st = 1'b0;

        for (int k = 0; k < 80; k++) applyStimulus();
        check("saturate_cnt", 8'(tick_cnt), 8'd15);
        check("saturate_tl", 8'(tl), 8'd1);

        st = 1'b1;
        applyStimulus();
        st = 1'b0;
        for (int k = 0; k < 16; k++) applyStimulus();
        check("cfg_pre_cnt", 8'(tick_cnt), 8'd4);
        check("cfg_pre_tl", 8'(tl), 8'd0);
        cfg_we   = 1'b1;
        cfg_sel  = 1'b1;
        cfg_data = 4'd2;
        applyStimulus();
        check("cfg_long2_tl", 8'(tl), 8'd1);
        cfg_data = 4'd6;
        applyStimulus();
        check("cfg_long6_tl", 8'(tl), 8'd0);
        cfg_sel  = 1'b0;
        cfg_data = 4'd0;
        st       = 1'b1;
        applyStimulus();
        cfg_we = 1'b0;
        st     = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            applyStimulus();
            if (k == 3) check("short0_ts_early", 8'(ts), 8'd0);
            if (k == 4) check("short0_ts_at_4", 8'(ts), 8'd1);
        end

        for (int s = 0; s < 3; s++) begin
            setRaw(s, 1'b1);
            for (int k = 0; k < 3; k++) applyStimulus();
            setRaw(s, 1'b0);
            for (int k = 0; k < 8; k++) applyStimulus();
            checkSensor(s, 1'b0);
            setRaw(s, 1'b1);
            for (int k = 1; k <= 6; k++) begin
                applyStimulus();
                if (k == 5) checkSensor(s, 1'b0);
                if (k == 6) checkSensor(s, 1'b1);
            end
        end

        st = 1'b1;
        applyStimulus();
        st = 1'b0;
        for (int k = 0; k < 5; k++) applyStimulus();
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        check("rst_c", 8'(c), 8'd0);
        check("rst_n", 8'(n), 8'd0);
        check("rst_p", 8'(p), 8'd0);
        check("rst_cnt", 8'(tick_cnt), 8'd0);
        checkOutput();
        applyStimulus();
        applyStimulus();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) applyStimulus();
        st = 1'b1;
        applyStimulus();
        st = 1'b0;
        for (int k = 0; k < 10; k++) applyStimulus();

        for (int k = 0; k < 1500; k++) begin
            st     = ($urandom_range(0, 39) == 0);
            cfg_we = ($urandom_range(0, 29) == 0);
            cfg_sel  = 1'($urandom_range(0, 1));
            cfg_data = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) c_raw = ~c_raw;
            if ($urandom_range(0, 5) == 0) n_raw = ~n_raw;
            if ($urandom_range(0, 5) == 0) p_raw = ~p_raw;
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
